// File: rtl/axi_mem_responder.sv
// AXI memory responder: byte-strobed 64-bit storage, independent read/write FSMs.
// Define AXI_RESP_ERR_EN to answer out-of-range bursts with SLVERR.

package ariane_axi;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

module axi_mem_responder
  import ariane_axi::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ariane_axi::req_t  axi_req_i,
  output ariane_axi::resp_t axi_resp_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  wstate_e r_wstate;
  wstate_e w_wstate_nxt;
  rstate_e r_rstate;
  rstate_e w_rstate_nxt;

  logic w_aw_ready;
  logic w_w_ready;
  logic w_b_valid;
  logic w_ar_ready;
  logic w_r_valid;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_oor;
  logic w_ar_oor;
  logic w_r_last;
  logic w_unused;

  logic [3:0]       r_aw_id;
  logic [IDX_W-1:0] r_aw_idx;
  logic [1:0]       r_aw_burst;
  logic             r_aw_err;
  logic [3:0]       r_ar_id;
  logic [IDX_W-1:0] r_ar_idx;
  logic [1:0]       r_ar_burst;
  logic             r_ar_err;
  logic [7:0]       r_ar_len;
  logic [7:0]       r_beat;

  logic [63:0] r_mem [MEM_WORDS];

`ifdef AXI_RESP_ERR_EN
  localparam logic [63:0] SPAN = 64'(MEM_WORDS) * 64'd8;
  localparam logic [63:0] TOP  = BASE_ADDR + SPAN;

  assign w_aw_oor = (axi_req_i.aw.addr < BASE_ADDR) ||
                    (axi_req_i.aw.addr >= TOP);
  assign w_ar_oor = (axi_req_i.ar.addr < BASE_ADDR) ||
                    (axi_req_i.ar.addr >= TOP);
`else
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
`endif

  // Only the index bits of the addresses and neither len on the W side matter.
  assign w_unused = ^{axi_req_i.aw.addr, axi_req_i.ar.addr,
                      axi_req_i.aw.len, BASE_ADDR};

  assign w_aw_hs  = axi_req_i.aw_valid & w_aw_ready;
  assign w_w_hs   = axi_req_i.w_valid  & w_w_ready;
  assign w_ar_hs  = axi_req_i.ar_valid & w_ar_ready;
  assign w_r_hs   = axi_req_i.r_ready  & w_r_valid;
  assign w_r_last = (r_beat == r_ar_len);

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_ready   = 1'b0;
    w_w_ready    = 1'b0;
    w_b_valid    = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_aw_ready = 1'b1;
        if (axi_req_i.aw_valid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        w_w_ready = 1'b1;
        if (axi_req_i.w_valid && axi_req_i.w.last)
          w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        w_b_valid = 1'b1;
        if (axi_req_i.b_ready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    if (rst_i) begin
      w_aw_ready = 1'b0;
      w_w_ready  = 1'b0;
      w_b_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_ready   = 1'b0;
    w_r_valid    = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_ar_ready = 1'b1;
        if (axi_req_i.ar_valid) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        w_r_valid = 1'b1;
        if (axi_req_i.r_ready && w_r_last) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
    if (rst_i) begin
      w_ar_ready = 1'b0;
      w_r_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // WRAP bursts advance like INCR; only FIXED holds the word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_id    <= '0;
      r_aw_idx   <= '0;
      r_aw_burst <= '0;
      r_aw_err   <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_id    <= axi_req_i.aw.id;
      r_aw_idx   <= axi_req_i.aw.addr[3 +: IDX_W];
      r_aw_burst <= axi_req_i.aw.burst;
      r_aw_err   <= w_aw_oor;
    end else if (w_w_hs && r_aw_burst != BURST_FIXED) begin
      r_aw_idx   <= r_aw_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ar_id    <= '0;
      r_ar_idx   <= '0;
      r_ar_burst <= '0;
      r_ar_err   <= 1'b0;
      r_ar_len   <= '0;
      r_beat     <= '0;
    end else if (w_ar_hs) begin
      r_ar_id    <= axi_req_i.ar.id;
      r_ar_idx   <= axi_req_i.ar.addr[3 +: IDX_W];
      r_ar_burst <= axi_req_i.ar.burst;
      r_ar_err   <= w_ar_oor;
      r_ar_len   <= axi_req_i.ar.len;
      r_beat     <= '0;
    end else if (w_r_hs) begin
      r_beat <= w_r_last ? '0 : r_beat + 8'd1;
      if (r_ar_burst != BURST_FIXED)
        r_ar_idx <= r_ar_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_w_hs && !r_aw_err) begin
      for (int b = 0; b < 8; b++) begin
        if (axi_req_i.w.strb[b])
          r_mem[r_aw_idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = w_aw_ready;
    axi_resp_o.w_ready  = w_w_ready;
    axi_resp_o.b_valid  = w_b_valid;
    axi_resp_o.ar_ready = w_ar_ready;
    axi_resp_o.r_valid  = w_r_valid;
    axi_resp_o.b.id     = r_aw_id;
    axi_resp_o.b.resp   = r_aw_err ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r.id     = r_ar_id;
    axi_resp_o.r.data   = r_ar_err ? '0 : r_mem[r_ar_idx];
    axi_resp_o.r.resp   = r_ar_err ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r.last   = w_r_last;
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, strobes, back-pressure,
// mid-burst reset and address wrap / range error.

module tb_axi_mem_responder;
  import ariane_axi::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  req_t  req;
  resp_t rsp;
  int    n_cmp = 0;
  int    n_err = 0;

  axi_mem_responder #(
    .MEM_WORDS(256),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .axi_req_i (req),
    .axi_resp_o(rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [63:0] a,
                       input logic [7:0] len, input logic [1:0] bu);
    int n = 0;
    req.aw = '{id: id, addr: a, len: len, burst: bu};
    req.aw_valid = 1'b1;
    while (rsp.aw_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout got=%b want=1", rsp.aw_ready);
    end
    tick();
    req.aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s,
                      input logic l);
    int n = 0;
    req.w = '{data: d, strb: s, last: l};
    req.w_valid = 1'b1;
    while (rsp.w_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      n_cmp++; n_err++;
      $display("FAIL w_timeout got=%b want=1", rsp.w_ready);
    end
    tick();
    req.w_valid = 1'b0;
  endtask

  task automatic do_b(output logic [3:0] id, output logic [1:0] rs);
    int n = 0;
    req.b_ready = 1'b1;
    while (rsp.b_valid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      n_cmp++; n_err++;
      $display("FAIL b_timeout got=%b want=1", rsp.b_valid);
    end
    id = rsp.b.id;
    rs = rsp.b.resp;
    tick();
    req.b_ready = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] a,
                       input logic [7:0] len, input logic [1:0] bu);
    int n = 0;
    req.ar = '{id: id, addr: a, len: len, burst: bu};
    req.ar_valid = 1'b1;
    while (rsp.ar_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout got=%b want=1", rsp.ar_ready);
    end
    tick();
    req.ar_valid = 1'b0;
  endtask

  task automatic do_r(output logic [63:0] d, output logic [3:0] id,
                      output logic l, output logic [1:0] rs);
    int n = 0;
    req.r_ready = 1'b1;
    while (rsp.r_valid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) begin
      n_cmp++; n_err++;
      $display("FAIL r_timeout got=%b want=1", rsp.r_valid);
    end
    d  = rsp.r.data;
    id = rsp.r.id;
    l  = rsp.r.last;
    rs = rsp.r.resp;
    tick();
    req.r_ready = 1'b0;
  endtask

  task automatic write_addr(input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s, output logic [1:0] rs);
    logic [3:0] id;
    do_aw(4'd0, a, 8'd0, INCR);
    do_w(d, s, 1'b1);
    do_b(id, rs);
  endtask

  task automatic read_addr(input logic [63:0] a, output logic [63:0] d);
    logic [3:0] id;
    logic       l;
    logic [1:0] rs;
    do_ar(4'd0, a, 8'd0, INCR);
    do_r(d, id, l, rs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready,
         rsp.b_valid, rsp.r_valid} !== 5'b0)
      begin n_err++;
        $display("FAIL reset_outputs got=%b want=00000",
                 {rsp.aw_ready, rsp.w_ready, rsp.ar_ready,
                  rsp.b_valid, rsp.r_valid});
      end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({rsp.aw_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid}
        !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_release got=%b want=1100",
               {rsp.aw_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid});
    end
  endtask

  task automatic test_incr_burst();
    logic [3:0]  id;
    logic [1:0]  rs;
    logic [63:0] d;
    logic        l;
    do_aw(4'b1100, BASE, 8'd3, INCR);
    for (int i = 0; i < 4; i++) do_w(64'(i + 1), 8'hFF, i == 3);
    do_b(id, rs);
    n_cmp++;
    if (id !== 4'b1100) begin
      n_err++; $display("FAIL b_id got=%b want=1100", id);
    end
    n_cmp++;
    if (rs !== 2'b00) begin
      n_err++; $display("FAIL b_resp got=%b want=00", rs);
    end
    do_ar(4'b0110, BASE, 8'd3, INCR);
    n_cmp++;
    if (rsp.r_valid !== 1'b1) begin
      n_err++; $display("FAIL r_latency got=%b want=1", rsp.r_valid);
    end
    for (int i = 0; i < 4; i++) begin
      do_r(d, id, l, rs);
      n_cmp++;
      if (d !== 64'(i + 1) || id !== 4'b0110) begin
        n_err++;
        $display("FAIL incr_beat%0d got=%h/%b want=%h/0110",
                 i, d, id, 64'(i + 1));
      end
      n_cmp++;
      if (l !== (i == 3)) begin
        n_err++; $display("FAIL incr_last%0d got=%b want=%b", i, l, i == 3);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0]  rs;
    logic [63:0] d;
    write_addr(BASE + 64'd40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rs);
    write_addr(BASE + 64'd40, 64'h0, 8'h0F, rs);
    read_addr(BASE + 64'd40, d);
    n_cmp++;
    if (d !== 64'hFFFF_FFFF_0000_0000) begin
      n_err++;
      $display("FAIL strobe got=%h want=ffffffff00000000", d);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  rs;
    logic [63:0] d;
    logic [3:0]  id;
    logic        l;
    write_addr(BASE + 64'd80, 64'hA0A0, 8'hFF, rs);
    write_addr(BASE + 64'd88, 64'hA1A1, 8'hFF, rs);
    do_ar(4'b1001, BASE + 64'd80, 8'd1, INCR);
    req.r_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({rsp.r_valid, rsp.r.data, rsp.r.id, rsp.r.last, rsp.ar_ready}
          !== {1'b1, 64'hA0A0, 4'b1001, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL hold%0d got v=%b d=%h id=%b l=%b ar=%b", c,
                 rsp.r_valid, rsp.r.data, rsp.r.id, rsp.r.last,
                 rsp.ar_ready);
      end
      tick();
    end
    do_r(d, id, l, rs);
    n_cmp++;
    if ({d, l, rsp.ar_ready} !== {64'hA0A0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL bp_beat0 got=%h/%b/%b want=a0a0/0/0",
               d, l, rsp.ar_ready);
    end
    do_r(d, id, l, rs);
    n_cmp++;
    if ({d, l, rsp.ar_ready} !== {64'hA1A1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL bp_beat1 got=%h/%b/%b want=a1a1/1/1",
               d, l, rsp.ar_ready);
    end
  endtask

  task automatic test_fixed_len0();
    logic [1:0]  rs;
    logic [63:0] d;
    logic [3:0]  id;
    logic        l;
    write_addr(BASE + 64'd168, 64'h5555, 8'hFF, rs);
    do_aw(4'd3, BASE + 64'd160, 8'd1, FIXED);
    do_w(64'hAAAA, 8'hFF, 1'b0);
    do_w(64'hBBBB, 8'hFF, 1'b1);
    do_b(id, rs);
    do_ar(4'd2, BASE + 64'd160, 8'd0, INCR);
    do_r(d, id, l, rs);
    n_cmp++;
    if ({d, l, rsp.ar_ready} !== {64'hBBBB, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL len0 got=%h/%b/%b want=bbbb/1/1",
               d, l, rsp.ar_ready);
    end
    read_addr(BASE + 64'd168, d);
    n_cmp++;
    if (d !== 64'h5555) begin
      n_err++; $display("FAIL fixed_neighbour got=%h want=5555", d);
    end
    do_ar(4'd4, BASE + 64'd160, 8'd2, FIXED);
    for (int i = 0; i < 3; i++) begin
      do_r(d, id, l, rs);
      n_cmp++;
      if ({d, l} !== {64'hBBBB, i == 2}) begin
        n_err++;
        $display("FAIL fixed_rd%0d got=%h/%b want=bbbb/%b", i, d, l, i == 2);
      end
    end
  endtask

  task automatic test_reset_midburst();
    logic [1:0]  rs;
    logic [63:0] d;
    write_addr(BASE,           64'h11, 8'hFF, rs);
    write_addr(BASE + 64'd8,   64'h22, 8'hFF, rs);
    write_addr(BASE + 64'd16,  64'h33, 8'hFF, rs);
    do_aw(4'd5, BASE, 8'd7, INCR);
    do_w(64'h100, 8'hFF, 1'b0);
    do_w(64'h101, 8'hFF, 1'b0);
    req.w = '{data: 64'h102, strb: 8'hFF, last: 1'b0};
    req.w_valid = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsp.w_ready, rsp.aw_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_ready got=%b want=00", {rsp.w_ready, rsp.aw_ready});
    end
    tick();
    req.w_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rsp.aw_ready, rsp.b_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_exit got=%b want=10", {rsp.aw_ready, rsp.b_valid});
    end
    req.b_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (rsp.b_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_no_b%0d got=%b want=0", c, rsp.b_valid);
      end
    end
    req.b_ready = 1'b0;
    read_addr(BASE, d);
    n_cmp++;
    if (d !== 64'h100) begin
      n_err++; $display("FAIL rst_word0 got=%h want=100", d);
    end
    read_addr(BASE + 64'd8, d);
    n_cmp++;
    if (d !== 64'h101) begin
      n_err++; $display("FAIL rst_word1 got=%h want=101", d);
    end
    read_addr(BASE + 64'd16, d);
    n_cmp++;
    if (d !== 64'h33) begin
      n_err++; $display("FAIL rst_word2 got=%h want=33", d);
    end
  endtask

  task automatic test_wrap_addr();
    logic [1:0]  rs;
    logic [1:0]  want_rs;
    logic [63:0] want255;
    logic [63:0] d;
    logic [3:0]  id;
    logic        l;
`ifdef AXI_RESP_ERR_EN
    write_addr(BASE + 64'd2040, 64'hCAFE, 8'hFF, rs);
    want_rs = 2'b10;
    want255 = 64'hCAFE;
`else
    want_rs = 2'b00;
    want255 = 64'hDEAD;
`endif
    write_addr(BASE - 64'd8, 64'hDEAD, 8'hFF, rs);
    n_cmp++;
    if (rs !== want_rs) begin
      n_err++; $display("FAIL wrap_bresp got=%b want=%b", rs, want_rs);
    end
    do_ar(4'd7, BASE + 64'd2040, 8'd1, INCR);
    do_r(d, id, l, rs);
    n_cmp++;
    if ({d, l} !== {want255, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_top got=%h/%b want=%h/0", d, l, want255);
    end
    do_r(d, id, l, rs);
    n_cmp++;
    if ({d, l} !== {64'h100, 1'b1}) begin
      n_err++; $display("FAIL wrap_zero got=%h/%b want=100/1", d, l);
    end
`ifdef AXI_RESP_ERR_EN
    do_ar(4'd7, BASE - 64'd8, 8'd0, INCR);
    do_r(d, id, l, rs);
    n_cmp++;
    if ({d, rs, l} !== {64'h0, 2'b10, 1'b1}) begin
      n_err++; $display("FAIL oor_read got=%h/%b/%b want=0/10/1", d, rs, l);
    end
`endif
  endtask

  initial begin
    req = '0;
    test_reset();
    test_incr_burst();
    test_strobe();
    test_backpressure();
    test_fixed_len0();
    test_reset_midburst();
    test_wrap_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MEM_WORDS, 256, number of 64-bit storage words; power of two, at least 2.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, synchronous active-high reset.
- axi_req_i, in, ariane_axi::req_t, AW/W/AR channels plus b_ready and r_ready from the initiator.
- axi_resp_o, out, ariane_axi::resp_t, ready signals plus B/R channels to the initiator.
REQ-003 Clocking and reset SHALL be: one clock, clk_i; reset rst_i is synchronous and active-high; there is no other clock or reset.

Function
REQ-004 Word index SHALL be addr[3 +: log2(MEM_WORDS)], taken modulo MEM_WORDS; the index wraps to 0 past the top word.
REQ-005 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
REQ-006 In W_IDLE, aw_ready SHALL be 1 and w_ready 0; an AW handshake captures id, addr, len and burst, then moves to W_DATA.
REQ-007 In W_DATA, w_ready SHALL be 1. Each W handshake writes the bytes of the current word whose strb bit is 1. The address then advances:
- INCR: +8.
- FIXED: held.
- WRAP: treated as INCR.
REQ-008 The W burst SHALL end on the w.last handshake, whatever len says, then move to W_RESP.
REQ-009 In W_RESP, b_valid SHALL be 1 with b.id equal to the captured id and b.resp OKAY (2'b00). b.id and b.resp SHALL be stable until b_ready; the B handshake returns to W_IDLE.
REQ-010 The read FSM SHALL have states R_IDLE and R_DATA.
REQ-011 In R_IDLE, ar_ready SHALL be 1; an AR handshake captures id, addr, len and burst, then moves to R_DATA.
REQ-012 r_valid SHALL first assert the cycle after the AR handshake (latency 1).
REQ-013 In R_DATA, r_valid SHALL be 1 with:
- r.data = mem[current index].
- r.id = captured id.
- r.last = 1 on beat number len.
REQ-014 Each R handshake SHALL advance the address per REQ-007. The handshake on the last beat returns to R_IDLE.
REQ-015 While r_ready is 0, all R outputs SHALL be held stable.
REQ-016 The read and write FSMs SHALL be independent; one transaction of each kind may be in flight at once.
REQ-017 A write to word k at edge t SHALL be visible to a read beat of word k presented at or after cycle t+1.
REQ-018 While a burst is in flight, the matching ar_ready/aw_ready SHALL be 0; only one outstanding burst per direction.
REQ-019 aw_ready SHALL be 0 in the cycle of the B handshake, and ar_ready SHALL be 0 in the cycle of the final R handshake.
REQ-020 len = 0 SHALL produce exactly one beat with last = 1; len = 255 SHALL produce exactly 256 beats.

Reset
REQ-021 While rst_i is sampled high:
- both FSMs go to idle.
- aw_ready, w_ready, ar_ready, b_valid and r_valid are 0.
- captured registers are cleared.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 Reset mid-burst SHALL abandon the burst: no B or R is issued afterwards, and words written before the reset keep their values.
REQ-024 On the first cycle after rst_i deasserts, aw_ready and ar_ready SHALL be 1.

Configuration
REQ-025 The macro AXI_RESP_ERR_EN SHALL select address-range checking:
- Defined: an AW/AR address outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*8) marks the burst as erroring. Its W beats are accepted but not written. B.resp is SLVERR (2'b10). Each R beat returns data 0 with resp SLVERR. Beat counts and handshakes are unchanged.
- Not defined: no range check; the index comes from the address bits only (REQ-004); resp is always OKAY.

Verification
REQ-026 AW{id=4'b1100, addr=BASE_ADDR, len=3, INCR}; 4 W beats of data 1..4, strb 8'hFF -> one B with id 4'b1100, resp OKAY; an AR of the same range returns 1,2,3,4 with last on beat 4 only.
REQ-027 Write 64'hFFFF_FFFF_FFFF_FFFF to word 5, then a single beat of 64'h0 with strb 8'h0F to word 5 -> reading word 5 returns 64'hFFFF_FFFF_0000_0000.
REQ-028 AR{id=4'b1001, len=1}; r_ready held 0 for 5 cycles -> r_valid stays 1 and r.data/r.id/r.last stay stable; 2 beats complete after r_ready rises; ar_ready is 0 throughout.
REQ-029 Assert rst_i in the 3rd beat of an 8-beat write -> no b_valid afterwards; aw_ready = 1 on the first cycle out of reset; words 0 and 1 are updated and word 2 is unchanged.
REQ-030 With AXI_RESP_ERR_EN defined, AW at BASE_ADDR - 8, len 0 -> B.resp 2'b10 and memory unchanged. Without the macro, the same address writes word MEM_WORDS-1 (wrap) with resp OKAY.
